// File: rtl/wb_trace_buffer.sv
// Writeback-trace capture unit: records retired instructions into a circular
// buffer with an optional PC-match trigger, post-trigger countdown and freeze.
module wb_trace_buffer #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic            clk_i,
  input  logic            rst_n,
  input  logic            wb_have_inst_i,
  input  logic [XLEN-1:0] wb_pc_i,
  input  logic            wb_ena_i,
  input  logic [4:0]      wb_reg_i,
  input  logic [XLEN-1:0] wb_value_i,
  input  logic            arm_i,
  input  logic            trig_en_i,
  input  logic [XLEN-1:0] trig_pc_i,
  input  logic [AW-1:0]   post_cnt_i,
  input  logic [AW-1:0]   rd_idx_i,
  output logic            rd_valid_o,
  output logic [XLEN-1:0] rd_pc_o,
  output logic            rd_ena_o,
  output logic [4:0]      rd_reg_o,
  output logic [XLEN-1:0] rd_value_o,
  output logic [AW:0]     count_o,
  output logic [1:0]      state_o,
  output logic [63:0]     inst_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    POST  = 2'b10,
    DONE  = 2'b11
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic            ena;
    logic [4:0]      rd;
    logic [XLEN-1:0] value;
  } entry_t;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] post_q, post_d;
  logic [63:0]   inst_cnt_q, inst_cnt_d;
  logic          rd_valid_q, rd_valid_d;
  entry_t        rd_entry_q, rd_entry_d;

  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  logic          capture;
  logic          trig_hit;
  logic [AW-1:0] oldest;
  logic [AW-1:0] rd_addr;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    post_d     = post_q;
    inst_cnt_d = inst_cnt_q + 64'(wb_have_inst_i);
    wr_entry   = '{pc: wb_pc_i, ena: wb_ena_i, rd: wb_reg_i, value: wb_value_i};
    // An arm pulse wins over a same-cycle retire: nothing stored, nothing matched.
    capture    = wb_have_inst_i && !arm_i && (state_q == ARMED || state_q == POST);
    trig_hit   = capture && (state_q == ARMED) && trig_en_i && (wb_pc_i == trig_pc_i);

    if (capture) begin
      wptr_d = wptr_q + 1'b1;
      if (count_q != FULL) count_d = count_q + 1'b1;
    end

    if (arm_i) begin
      state_d = ARMED;
      wptr_d  = '0;
      count_d = '0;
      post_d  = '0;
    end else begin
      unique case (state_q)
        ARMED: if (trig_hit) begin
          if (post_cnt_i != '0) begin
            state_d = POST;
            post_d  = post_cnt_i;
          end else begin
            state_d = DONE;
          end
        end
        POST: if (capture) begin
          post_d = post_q - 1'b1;
          if (post_q == AW'(1)) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  // Once the ring has wrapped, the slot about to be overwritten is the oldest.
  always_comb begin
    oldest     = (count_q == FULL) ? wptr_q : '0;
    rd_addr    = oldest + rd_idx_i;
    rd_valid_d = ({1'b0, rd_idx_i} < count_q);
    rd_entry_d = rd_valid_d ? mem[rd_addr] : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; this is also what makes readout read-before-write.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      count_q    <= '0;
      post_q     <= '0;
      inst_cnt_q <= '0;
      rd_valid_q <= 1'b0;
      rd_entry_q <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      inst_cnt_q <= inst_cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_entry_q <= rd_entry_d;
    end
  end

  // NOTE: trace storage is not reset; count_o gates which slots are readable,
  // and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (capture) mem[wptr_q] <= wr_entry;
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_pc_o    = rd_entry_q.pc;
  assign rd_ena_o   = rd_entry_q.ena;
  assign rd_reg_o   = rd_entry_q.rd;
  assign rd_value_o = rd_entry_q.value;
  assign count_o    = count_q;
  assign state_o    = state_q;
  assign inst_cnt_o = inst_cnt_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer: ring capture, trigger/post countdown,
// re-arm, field integrity, readout bounds and asynchronous reset.
module tb_wb_trace_buffer;

  localparam int XLEN  = 32;
  localparam int DEPTH = 64;
  localparam int AW    = $clog2(DEPTH);

  logic            clk_i = 1'b0;
  logic            rst_n = 1'b0;
  logic            wb_have_inst_i = 1'b0;
  logic [XLEN-1:0] wb_pc_i = '0;
  logic            wb_ena_i = 1'b0;
  logic [4:0]      wb_reg_i = '0;
  logic [XLEN-1:0] wb_value_i = '0;
  logic            arm_i = 1'b0;
  logic            trig_en_i = 1'b0;
  logic [XLEN-1:0] trig_pc_i = '0;
  logic [AW-1:0]   post_cnt_i = '0;
  logic [AW-1:0]   rd_idx_i = '0;
  logic            rd_valid_o;
  logic [XLEN-1:0] rd_pc_o;
  logic            rd_ena_o;
  logic [4:0]      rd_reg_o;
  logic [XLEN-1:0] rd_value_o;
  logic [AW:0]     count_o;
  logic [1:0]      state_o;
  logic [63:0]     inst_cnt_o;

  int checks   = 0;
  int failures = 0;

  wb_trace_buffer #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .wb_have_inst_i (wb_have_inst_i),
    .wb_pc_i        (wb_pc_i),
    .wb_ena_i       (wb_ena_i),
    .wb_reg_i       (wb_reg_i),
    .wb_value_i     (wb_value_i),
    .arm_i          (arm_i),
    .trig_en_i      (trig_en_i),
    .trig_pc_i      (trig_pc_i),
    .post_cnt_i     (post_cnt_i),
    .rd_idx_i       (rd_idx_i),
    .rd_valid_o     (rd_valid_o),
    .rd_pc_o        (rd_pc_o),
    .rd_ena_o       (rd_ena_o),
    .rd_reg_o       (rd_reg_o),
    .rd_value_o     (rd_value_o),
    .count_o        (count_o),
    .state_o        (state_o),
    .inst_cnt_o     (inst_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic retire(input logic [XLEN-1:0] pc, input logic ena,
                        input logic [4:0] rd, input logic [XLEN-1:0] val);
    wb_have_inst_i = 1'b1;
    wb_pc_i        = pc;
    wb_ena_i       = ena;
    wb_reg_i       = rd;
    wb_value_i     = val;
    step();
    wb_have_inst_i = 1'b0;
  endtask

  task automatic arm();
    arm_i = 1'b1;
    step();
    arm_i = 1'b0;
  endtask

  task automatic read(input logic [AW-1:0] idx);
    rd_idx_i = idx;
    step();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_state", 64'(state_o), 64'h0);
    check("rst_count", 64'(count_o), 64'h0);
    check("rst_inst", inst_cnt_o, 64'h0);
    check("rst_valid", 64'(rd_valid_o), 64'h0);
    step();
    rst_n = 1'b1;
    step();

    // Idle retires: counted but not stored
    for (int i = 0; i < 10; i++) retire(32'(i * 4), 1'b0, 5'd0, 32'h0);
    read('0);
    check("idle_state", 64'(state_o), 64'h0);
    check("idle_count", 64'(count_o), 64'h0);
    check("idle_inst", inst_cnt_o, 64'd10);
    check("idle_valid", 64'(rd_valid_o), 64'h0);

    // Free-running ring
    trig_en_i = 1'b0;
    arm();
    check("arm_state", 64'(state_o), 64'h1);
    for (int i = 0; i < 70; i++) retire(32'(i * 4), 1'b1, 5'(i), 32'(i));
    check("ring_count", 64'(count_o), 64'd64);
    check("ring_state", 64'(state_o), 64'h1);
    check("ring_inst", inst_cnt_o, 64'd80);
    read(6'd0);
    check("ring_old_pc", 64'(rd_pc_o), 64'h18);
    check("ring_old_valid", 64'(rd_valid_o), 64'h1);
    read(6'd63);
    check("ring_new_pc", 64'(rd_pc_o), 64'h114);
    check("ring_new_val", 64'(rd_value_o), 64'd69);

    // Trigger with three post entries
    trig_en_i  = 1'b1;
    trig_pc_i  = 32'h40;
    post_cnt_i = 6'd3;
    arm();
    for (int i = 0; i < 20; i++) begin
      retire(32'(i * 4), 1'b0, 5'd1, 32'h0);
      if (i == 15) check("trg_pre_state", 64'(state_o), 64'h1);
      if (i == 16) check("trg_hit_state", 64'(state_o), 64'h2);
      if (i == 18) check("trg_post_state", 64'(state_o), 64'h2);
    end
    check("trg_done_state", 64'(state_o), 64'h3);
    check("trg_count", 64'(count_o), 64'd20);
    retire(32'h50, 1'b0, 5'd1, 32'h0);
    check("trg_frozen_count", 64'(count_o), 64'd20);
    read(6'd19);
    check("trg_last_pc", 64'(rd_pc_o), 64'h4C);
    read(6'd16);
    check("trg_entry_pc", 64'(rd_pc_o), 64'h40);
    read(6'd20);
    check("trg_oob_valid", 64'(rd_valid_o), 64'h0);
    check("trg_inst", inst_cnt_o, 64'd101);

    // Zero post count, then re-arm with a simultaneous retire
    post_cnt_i = 6'd0;
    trig_pc_i  = 32'h8;
    arm();
    for (int i = 0; i < 3; i++) retire(32'(i * 4), 1'b0, 5'd2, 32'h0);
    check("zp_state", 64'(state_o), 64'h3);
    check("zp_count", 64'(count_o), 64'd3);
    arm_i = 1'b1;
    retire(32'h8, 1'b1, 5'd3, 32'h5);
    arm_i = 1'b0;
    check("rearm_count", 64'(count_o), 64'd0);
    check("rearm_state", 64'(state_o), 64'h1);
    check("rearm_inst", inst_cnt_o, 64'd105);

    // Field integrity and readout bound
    trig_en_i = 1'b0;
    retire(32'h8000_0000, 1'b1, 5'd31, 32'hDEAD_BEEF);
    check("fld_count", 64'(count_o), 64'd1);
    read(6'd0);
    check("fld_valid", 64'(rd_valid_o), 64'h1);
    check("fld_pc", 64'(rd_pc_o), 64'h8000_0000);
    check("fld_ena", 64'(rd_ena_o), 64'h1);
    check("fld_reg", 64'(rd_reg_o), 64'd31);
    check("fld_value", 64'(rd_value_o), 64'hDEAD_BEEF);
    read(6'd1);
    check("oob_valid", 64'(rd_valid_o), 64'h0);
    check("oob_data", {rd_pc_o, rd_value_o}, 64'h0);
    check("oob_fields", {57'h0, rd_ena_o, 1'b0, rd_reg_o}, 64'h0);

    // Async reset mid-POST
    trig_en_i  = 1'b1;
    trig_pc_i  = 32'h10;
    post_cnt_i = 6'd5;
    arm();
    for (int i = 0; i < 6; i++) retire(32'(i * 4), 1'b1, 5'd4, 32'h1);
    read(6'd4);
    check("ar_pre_state", 64'(state_o), 64'h2);
    check("ar_pre_pc", 64'(rd_pc_o), 64'h10);
    @(posedge clk_i);
    #2 rst_n = 1'b0;
    #1;
    check("ar_state", 64'(state_o), 64'h0);
    check("ar_count", 64'(count_o), 64'h0);
    check("ar_inst", inst_cnt_o, 64'h0);
    check("ar_valid", 64'(rd_valid_o), 64'h0);
    check("ar_data", {rd_pc_o, rd_value_o}, 64'h0);
    check("ar_fields", {57'h0, rd_ena_o, 1'b0, rd_reg_o}, 64'h0);
    step();
    rst_n = 1'b1;
    step();
    check("ar_release_state", 64'(state_o), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
